// File: rtl/matrix_operand_loader.sv
// -----------------------------------------------------------------------------
// matrix_operand_loader
//
// Upstream feeder for the 2x2 matrix multiplier. It collects a serial stream of
// eight DATA_W-bit elements (A00, A01, A10, A11, B00, B01, B10, B11) into an
// assembly buffer. It presents each completed pair as two packed words through
// an output register. Together, the buffer and the register form a two-deep
// pipeline, so the next pair can fill while the current one waits downstream.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid && ready are both 1. A producer that raises valid keeps it and
// its payload stable until that edge. in_ready depends only on FSM state.
// out_a/out_b do not change while out_valid && !out_ready.
//
// Optional feature: define MATLOAD_LAST_CHECK_EN to check in_last framing.
// When the macro is undefined, in_last is ignored and err_framing is 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready element handshake; in_data = element, in_last = 8th mark
//   out_valid/out_ready pair handshake; out_a = {a00,a01,a10,a11},
//                     out_b = {b00,b01,b10,b11}, first element in the MSBs
//   err_framing       sticky framing-error flag (cleared only by reset)
//   dbg_state         FSM state (0 = FILL, 1 = FULL)
//   dbg_idx           current assembly slot index
// -----------------------------------------------------------------------------
module matrix_operand_loader #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DATA_W-1:0] out_a,
  output logic [4*DATA_W-1:0] out_b,
  output logic                err_framing,
  output logic                dbg_state,
  output logic [2:0]          dbg_idx
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic [7:0][DATA_W-1:0]   buf_q, buf_d;
  logic                     out_valid_q, out_valid_d;
  logic [4*DATA_W-1:0]      out_a_q, out_a_d;
  logic [4*DATA_W-1:0]      out_b_q, out_b_d;
  logic                     err_q, err_d;

  logic accept;
  logic drain;
  logic last_slot;
  logic wr_en;
  logic complete;
  logic load_new;
  logic load_buf;
  logic load;
  logic frame_discard;
  logic frame_err;

  // ---------------------------------------------------------------------------
  // Handshake decode and framing
  // ---------------------------------------------------------------------------
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;
  assign last_slot = (idx_q == 3'd7);

`ifdef MATLOAD_LAST_CHECK_EN
  // An early in_last throws away the partial pair and the marked element.
  // A missing in_last on slot 7 is flagged, but the pair still completes.
  assign frame_discard = accept && in_last && !last_slot;
  assign frame_err     = frame_discard || (accept && last_slot && !in_last);
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign frame_discard  = 1'b0;
  assign frame_err      = 1'b0;
`endif

  assign wr_en    = accept && !frame_discard;
  assign complete = accept && last_slot;
  // A finished pair may go straight to the output register if that register
  // is empty or is being emptied on this same edge.
  assign load_new = complete && (!out_valid_q || drain);
  assign load_buf = (state_q == S_FULL) && drain;
  assign load     = load_new || load_buf;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    buf_d = buf_q;
    if (wr_en) begin
      buf_d[idx_q] = in_data;
    end

    idx_d = idx_q;
    if (frame_discard) begin
      idx_d = 3'd0;
    end else if (wr_en) begin
      // 7 -> 0 wraps only on the completing write.
      idx_d = idx_q + 3'd1;
    end

    // buf_d already includes the slot-7 element written this cycle. In FULL
    // no writes occur, so buf_d equals the held buffer.
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_a_d     = {buf_d[0], buf_d[1], buf_d[2], buf_d[3]};
      out_b_d     = {buf_d[4], buf_d[5], buf_d[6], buf_d[7]};
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end

    err_d = err_q | frame_err;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: if (complete && !load_new) state_d = S_FULL;
      S_FULL: if (drain)                 state_d = S_FILL;
      default:                           state_d = S_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == S_FILL);
    dbg_state = state_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      idx_q       <= 3'd0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      err_q       <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign err_framing = err_q;
  assign dbg_idx     = idx_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// -----------------------------------------------------------------------------
// Testbench for matrix_operand_loader.
// A driver feeds elements, and a reference model turns accepted elements into
// expected pairs. A monitor pops those pairs and compares them on every output
// handshake. Build with +define+MATLOAD_LAST_CHECK_EN to exercise the framing
// checks.
// -----------------------------------------------------------------------------
module tb_matrix_operand_loader;

`ifdef MATLOAD_LAST_CHECK_EN
  localparam bit LAST_CHK = 1'b1;
`else
  localparam bit LAST_CHK = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        err_framing;
  logic        dbg_state;
  logic [2:0]  dbg_idx;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_operand_loader #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .err_framing (err_framing),
    .dbg_state   (dbg_state),
    .dbg_idx     (dbg_idx)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  int          hs_cyc[$];
  logic [7:0]  model_elems[$];
  bit          exp_err = 1'b0;
  bit          in_ready_dropped = 1'b0;
  bit          rand_done = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: a list of accepted elements. Eight elements make a pair,
  // with the first element in the most significant byte.
  function automatic void model_accept(logic [7:0] d, bit last);
    logic [63:0] p;
    if (LAST_CHK && last && model_elems.size() < 7) begin
      model_elems.delete();
      exp_err = 1'b1;
      return;
    end
    model_elems.push_back(d);
    if (model_elems.size() == 8) begin
      if (LAST_CHK && !last) exp_err = 1'b1;
      p = 64'd0;
      for (int i = 0; i < 8; i++) p = (p << 8) | 64'(model_elems[i]);
      exp_q.push_back(p);
      model_elems.delete();
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge + #1)
  // ---------------------------------------------------------------------------
  task automatic send_elem(input logic [7:0] d, input bit last, input int gap);
    int  waited;
    bit  done;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d, last);
        done = 1'b1;
      end else begin
        in_ready_dropped = 1'b1;
        waited++;
      end
      @(posedge clk);
      #1;
      if (!done && waited > 200) begin
        check("in_ready timeout", 64'(in_ready), 64'd1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_elem(8'(base + 8'(i)), (i % 8) == 7, 0);
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain pending pairs", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, " in_ready"},    64'(in_ready),    64'd1);
    check({tag, " out_valid"},   64'(out_valid),   64'd0);
    check({tag, " out_a"},       64'(out_a),       64'd0);
    check({tag, " out_b"},       64'(out_b),       64'd0);
    check({tag, " err_framing"}, 64'(err_framing), 64'd0);
    check({tag, " idx"},         64'(dbg_idx),     64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pair compare on handshake, stability while stalled
  // ---------------------------------------------------------------------------
  bit          hold_v = 1'b0;
  logic [63:0] hold_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) check("stall stability", {out_a, out_b}, hold_d);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected pair: got %0h expected none", {out_a, out_b});
        end else begin
          check("pair", {out_a, out_b}, exp_q.pop_front());
          hs_cyc.push_back(cyc);
        end
        hold_v = 1'b0;
      end else begin
        hold_v = out_valid;
        hold_d = {out_a, out_b};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pair, latency check.
    out_ready = 1'b1;
    send_seq(8'd1, 8);
    check("latency out_valid", 64'(out_valid), 64'd1);
    check("single pair data", {out_a, out_b}, 64'h01020304_05060708);
    check("err clean", 64'(err_framing), 64'd0);
    wait_empty();

    // Back-to-back, no bubbles.
    in_ready_dropped = 1'b0;
    hs_cyc.delete();
    send_seq(8'd1, 16);
    wait_empty();
    check("in_ready never drops", 64'(in_ready_dropped), 64'd0);
    check("pairs seen", 64'(hs_cyc.size()), 64'd2);
    if (hs_cyc.size() >= 2) check("pair spacing", 64'(hs_cyc[1] - hs_cyc[0]), 64'd8);

    // Back-pressure: 16 absorbed, then in_ready falls.
    out_ready = 1'b0;
    send_seq(8'd1, 16);
    check("bp in_ready low", 64'(in_ready), 64'd0);
    check("bp state FULL", 64'(dbg_state), 64'd1);
    check("bp holds pair1", {out_a, out_b}, 64'h01020304_05060708);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp out_valid kept", 64'(out_valid), 64'd1);
    check("bp pair2 loaded", {out_a, out_b}, 64'h090A0B0C_0D0E0F10);
    check("bp in_ready back", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    wait_empty();

    // 8th accept coinciding with output handshake.
    out_ready = 1'b0;
    send_seq(8'h21, 8);
    send_seq(8'h31, 7);
    out_ready = 1'b1;
    send_elem(8'h38, 1'b1, 0);
    check("simul out_valid", 64'(out_valid), 64'd1);
    check("simul new data", {out_a, out_b}, 64'h31323334_35363738);
    wait_empty();

    // Early in_last discards the partial pair.
    if (LAST_CHK) begin
      send_elem(8'd1, 1'b0, 0);
      send_elem(8'd2, 1'b0, 0);
      send_elem(8'd3, 1'b1, 0);
      check("framing err set", 64'(err_framing), 64'd1);
      check("framing idx reset", 64'(dbg_idx), 64'd0);
      send_seq(8'd1, 8);
      check("framing next pair", {out_a, out_b}, 64'h01020304_05060708);
      wait_empty();
      check("framing err sticky", 64'(err_framing), 64'd1);
    end

    // Reset mid-operation.
    out_ready = 1'b0;
    send_seq(8'h41, 8);
    send_seq(8'h51, 5);
    rst_n = 1'b0;
    #2;
    check_reset_vals("mid reset");
    model_elems.delete();
    exp_q.delete();
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_seq(8'd1, 8);
    check("post reset data", {out_a, out_b}, 64'h01020304_05060708);
    wait_empty();

    // Random traffic with random back-pressure.
    rand_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 20; p++) begin
          for (int i = 0; i < 8; i++) begin
            bit lst;
            if (LAST_CHK) lst = (i == 7) ^ ($urandom_range(0, 15) == 0);
            else          lst = 1'($urandom_range(0, 1));
            send_elem(8'($urandom_range(0, 255)), lst, $urandom_range(0, 2));
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_empty();
    check("final err_framing", 64'(err_framing), 64'(exp_err));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
